// File: rtl/icache_refill.sv
// Direct-mapped instruction cache with a single outstanding line refill and fetch-batch responses.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_refill #(
    parameter int LINE_NUM       = 4,
    parameter int WORDS_PER_LINE = 16,
    parameter int WORD_WIDTH     = 32,
    parameter int FETCH_WIDTH    = 4,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fetch_valid,
    output logic                               fetch_ready,
    input  logic [ADDR_WIDTH-1:0]              fetch_addr,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [FETCH_WIDTH*WORD_WIDTH-1:0]  inst_batch,
    output logic [FETCH_WIDTH-1:0]             batch_mask,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_WIDTH-1:0]              mem_req_addr,
    input  logic                               mem_resp_valid,
    input  logic [WORD_WIDTH-1:0]              mem_resp_data,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]                        hit_cnt,
    output logic [31:0]                        miss_cnt,
`endif
    input  logic                               flush
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam logic [WORD_WIDTH-1:0] NOP_WORD = WORD_WIDTH'(32'h0000_0013);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL} state_t;

    state_t                 state;
    logic [LINE_NUM-1:0]    valid;
    logic [TAG_W-1:0]       tags     [LINE_NUM];
    logic [WORD_WIDTH-1:0]  data_mem [LINE_NUM*WORDS_PER_LINE];

    logic [OFF_W-1:0]       req_offset;
    logic [IDX_W-1:0]       req_index;
    logic [TAG_W-1:0]       req_tag;
    logic [OFF_W-1:0]       beat_cnt;
    logic                   flush_pending;

    logic [OFF_W-1:0]       fetch_offset;
    logic [IDX_W-1:0]       fetch_index;
    logic [TAG_W-1:0]       fetch_tag;
    logic                   fetch_accept;
    logic                   fetch_hit;
    logic                   refill_beat;
    logic                   refill_last;

    logic [OFF_W-1:0]       sel_offset;
    logic [IDX_W-1:0]       sel_index;
    logic [OFF_W:0]         slot_sum;
    logic [FETCH_WIDTH*WORD_WIDTH-1:0] next_batch;
    logic [FETCH_WIDTH-1:0] next_mask;

    assign fetch_offset = fetch_addr[OFF_W-1:0];
    assign fetch_index  = fetch_addr[OFF_W +: IDX_W];
    assign fetch_tag    = fetch_addr[ADDR_WIDTH-1 -: TAG_W];

    assign fetch_ready  = (state == IDLE) && !flush && (!resp_valid || resp_ready);
    assign fetch_accept = fetch_valid && fetch_ready;
    assign fetch_hit    = valid[fetch_index] && (tags[fetch_index] == fetch_tag);
    assign refill_beat  = (state == REFILL) && mem_resp_valid;
    assign refill_last  = refill_beat && (beat_cnt == LAST_WORD);

    // The final refill beat is not in the array yet, so it is forwarded straight into its slot.
    always_comb begin
        sel_offset = (state == IDLE) ? fetch_offset : req_offset;
        sel_index  = (state == IDLE) ? fetch_index  : req_index;
        next_batch = '0;
        next_mask  = '0;
        slot_sum   = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_sum = {1'b0, sel_offset} + (OFF_W+1)'(i);
            if (!slot_sum[OFF_W]) begin
                next_mask[i] = 1'b1;
                if ((state == REFILL) && (slot_sum[OFF_W-1:0] == LAST_WORD))
                    next_batch[i*WORD_WIDTH +: WORD_WIDTH] = mem_resp_data;
                else
                    next_batch[i*WORD_WIDTH +: WORD_WIDTH] = data_mem[{sel_index, slot_sum[OFF_W-1:0]}];
            end else begin
                next_batch[i*WORD_WIDTH +: WORD_WIDTH] = NOP_WORD;
            end
        end
    end

    // Data and tag storage carry no reset; only the valid bits decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (!rst && refill_beat)
            data_mem[{req_index, beat_cnt}] <= mem_resp_data;
        if (!rst && refill_last)
            tags[req_index] <= req_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            beat_cnt      <= '0;
            resp_valid    <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            inst_batch    <= '0;
            batch_mask    <= '0;
            req_offset    <= '0;
            req_index     <= '0;
            req_tag       <= '0;
            flush_pending <= 1'b0;
`ifdef ICACHE_PERF_CNT_EN
            hit_cnt       <= '0;
            miss_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (resp_valid && resp_ready)
                        resp_valid <= 1'b0;
                    if (fetch_accept) begin
                        if (fetch_hit) begin
                            resp_valid <= 1'b1;
                            inst_batch <= next_batch;
                            batch_mask <= next_mask;
`ifdef ICACHE_PERF_CNT_EN
                            hit_cnt    <= hit_cnt + 32'd1;
`endif
                        end else begin
                            req_offset    <= fetch_offset;
                            req_index     <= fetch_index;
                            req_tag       <= fetch_tag;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {fetch_tag, fetch_index, OFF_W'(0)};
                            flush_pending <= 1'b0;
                            state         <= MISS_REQ;
`ifdef ICACHE_PERF_CNT_EN
                            miss_cnt      <= miss_cnt + 32'd1;
`endif
                        end
                    end
                end
                MISS_REQ: begin
                    if (flush)
                        flush_pending <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush)
                        flush_pending <= 1'b1;
                    if (refill_beat)
                        beat_cnt <= beat_cnt + OFF_W'(1);
                    if (refill_last) begin
                        if (!flush_pending)
                            valid[req_index] <= 1'b1;
                        resp_valid <= 1'b1;
                        inst_batch <= next_batch;
                        batch_mask <= next_mask;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A flush in the same cycle as refill completion must also win over the valid set.
            if (flush)
                valid <= '0;
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Directed testbench for icache_refill with a simple line-fill memory model.
// Perf counter checks are compiled in only when ICACHE_PERF_CNT_EN is defined.
module tb_icache_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic         fetch_valid;
    logic         fetch_ready;
    logic [15:0]  fetch_addr;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] inst_batch;
    logic [3:0]   batch_mask;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [15:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [31:0]  mem_resp_data;
    logic         flush;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
    logic [31:0]  miss_before;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [15:0]  got_addr;
    logic [127:0] held_batch;

    icache_refill dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .inst_batch(inst_batch), .batch_mask(batch_mask),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
`ifdef ICACHE_PERF_CNT_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Presents one fetch and returns at the negedge right after it was accepted.
    task automatic applyStimulus(input logic [15:0] addr);
        int n;
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_addr  = addr;
        n = 0;
        while (!fetch_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!fetch_ready) checkOutput("fetch_ready_timeout", 128'd0, 128'd1);
        @(negedge clk);
        fetch_valid = 1'b0;
    endtask

    // Memory model: accepts the line request, then streams 'beats' words of 0x1000*(line)+k.
    task automatic serveMem(input int beats, output logic [15:0] req_addr);
        int n;
        n = 0;
        req_addr = 16'hFFFF;
        while (!mem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req_valid) begin
            checkOutput("mem_req_timeout", 128'd0, 128'd1);
            return;
        end
        req_addr = mem_req_addr;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int k = 0; k < beats; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h1000 * 32'(req_addr >> 4) + 32'(k);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; resp_ready = 1'b1;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_resp_valid", 128'(resp_valid), 128'd0);
        checkOutput("rst_mem_req_valid", 128'(mem_req_valid), 128'd0);
        checkOutput("rst_inst_batch", inst_batch, 128'd0);
        checkOutput("rst_batch_mask", 128'(batch_mask), 128'd0);
        checkOutput("rst_fetch_ready", 128'(fetch_ready), 128'd1);
        rst = 1'b0;

        // Cold miss
        applyStimulus(16'h0005);
        checkOutput("cold_req_valid", 128'(mem_req_valid), 128'd1);
        checkOutput("cold_no_resp", 128'(resp_valid), 128'd0);
        serveMem(16, got_addr);
        checkOutput("cold_req_addr", 128'(got_addr), 128'h0000);
        checkOutput("cold_resp_valid", 128'(resp_valid), 128'd1);
        checkOutput("cold_batch", inst_batch, {32'h8, 32'h7, 32'h6, 32'h5});
        checkOutput("cold_mask", 128'(batch_mask), 128'hF);
        @(negedge clk);
        checkOutput("cold_resp_drop", 128'(resp_valid), 128'd0);

        // Hit
        applyStimulus(16'h0006);
        checkOutput("hit_resp_valid", 128'(resp_valid), 128'd1);
        checkOutput("hit_no_mem_req", 128'(mem_req_valid), 128'd0);
        checkOutput("hit_batch", inst_batch, {32'h9, 32'h8, 32'h7, 32'h6});
        checkOutput("hit_mask", 128'(batch_mask), 128'hF);
        @(negedge clk);

        // Line-end batch, held under backpressure
        resp_ready = 1'b0;
        applyStimulus(16'h000E);
        checkOutput("end_resp_valid", 128'(resp_valid), 128'd1);
        checkOutput("end_batch", inst_batch, {32'h13, 32'h13, 32'hF, 32'hE});
        checkOutput("end_mask", 128'(batch_mask), 128'h3);
        held_batch = {32'h13, 32'h13, 32'hF, 32'hE};
        @(negedge clk);
        checkOutput("stall_resp_valid", 128'(resp_valid), 128'd1);
        checkOutput("stall_batch", inst_batch, held_batch);
        checkOutput("stall_fetch_ready", 128'(fetch_ready), 128'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_release", 128'(resp_valid), 128'd0);

        // Conflict miss on index 0, then original line misses again
        applyStimulus(16'h0040);
        checkOutput("conf_req_valid", 128'(mem_req_valid), 128'd1);
        serveMem(16, got_addr);
        checkOutput("conf_req_addr", 128'(got_addr), 128'h0040);
        checkOutput("conf_batch", inst_batch, {32'h4003, 32'h4002, 32'h4001, 32'h4000});
        applyStimulus(16'h0005);
        checkOutput("evict_req_valid", 128'(mem_req_valid), 128'd1);
        serveMem(16, got_addr);
        checkOutput("evict_req_addr", 128'(got_addr), 128'h0000);
        checkOutput("evict_batch", inst_batch, {32'h8, 32'h7, 32'h6, 32'h5});

`ifdef ICACHE_PERF_CNT_EN
        checkOutput("hit_cnt", 128'(hit_cnt), 128'd2);
        checkOutput("miss_cnt", 128'(miss_cnt), 128'd3);
        miss_before = miss_cnt;
`endif
        // Flush then refetch
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        applyStimulus(16'h0006);
        checkOutput("flush_req_valid", 128'(mem_req_valid), 128'd1);
        serveMem(16, got_addr);
        checkOutput("flush_req_addr", 128'(got_addr), 128'h0000);
        checkOutput("flush_batch", inst_batch, {32'h9, 32'h8, 32'h7, 32'h6});
`ifdef ICACHE_PERF_CNT_EN
        checkOutput("flush_miss_inc", 128'(miss_cnt - miss_before), 128'd1);
`endif

        // Flush during MISS_REQ: response still returned, line left invalid
        applyStimulus(16'h0020);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        serveMem(16, got_addr);
        checkOutput("fmiss_req_addr", 128'(got_addr), 128'h0020);
        checkOutput("fmiss_resp_valid", 128'(resp_valid), 128'd1);
        checkOutput("fmiss_batch", inst_batch, {32'h2003, 32'h2002, 32'h2001, 32'h2000});
        applyStimulus(16'h0021);
        checkOutput("fmiss_refetch_miss", 128'(mem_req_valid), 128'd1);
        serveMem(16, got_addr);
        checkOutput("fmiss_refetch_batch", inst_batch, {32'h2004, 32'h2003, 32'h2002, 32'h2001});

        // Reset after 7 refill beats, stray beats afterwards are ignored
        applyStimulus(16'h0030);
        serveMem(7, got_addr);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_mem_req_valid", 128'(mem_req_valid), 128'd0);
        checkOutput("midrst_resp_valid", 128'(resp_valid), 128'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        mem_resp_valid = 1'b0;
        checkOutput("midrst_stray_resp", 128'(resp_valid), 128'd0);
        applyStimulus(16'h0030);
        checkOutput("midrst_fresh_req", 128'(mem_req_valid), 128'd1);
        serveMem(16, got_addr);
        checkOutput("midrst_req_addr", 128'(got_addr), 128'h0030);
        checkOutput("midrst_batch", inst_batch, {32'h3003, 32'h3002, 32'h3001, 32'h3000});
        checkOutput("midrst_mask", 128'(batch_mask), 128'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameter LINE_NUM, default 4: direct-mapped lines, power of two, >=2.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 16: words per line, power of two, >=FETCH_WIDTH.
REQ-003 SHALL have parameter WORD_WIDTH, default 32: instruction width.
REQ-004 SHALL have parameter FETCH_WIDTH, default 4: instructions per response, power of two.
REQ-005 SHALL have parameter ADDR_WIDTH, default 16: word-address width, > log2(LINE_NUM)+log2(WORDS_PER_LINE).
REQ-006 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: fetch_valid in 1 request; fetch_ready out 1 accept; fetch_addr in ADDR_WIDTH word address.
REQ-008 SHALL have ports: resp_valid out 1; resp_ready in 1; inst_batch out FETCH_WIDTH*WORD_WIDTH, slot i at bits [i*WORD_WIDTH +: WORD_WIDTH]; batch_mask out FETCH_WIDTH, per-slot valid.
REQ-009 SHALL have ports: mem_req_valid out 1; mem_req_ready in 1; mem_req_addr out ADDR_WIDTH line-aligned; mem_resp_valid in 1; mem_resp_data in WORD_WIDTH, one word per beat, ascending order.
REQ-010 SHALL have port flush in 1: invalidate all lines.

Function
REQ-011 SHALL decode offset=addr[log2(W)-1:0], index=next log2(LINE_NUM) bits, tag=remaining upper bits.
REQ-012 SHALL implement FSM IDLE -> MISS_REQ -> REFILL -> IDLE; hits stay in IDLE.
REQ-013 SHALL drive fetch_ready = (state==IDLE) && !flush && (!resp_valid || resp_ready).
REQ-014 Hit (valid[index] && tag match) on accept at cycle T SHALL assert resp_valid at T+1 with registered data.
REQ-015 Miss at T SHALL enter MISS_REQ, assert mem_req_valid from T+1 with mem_req_addr = {tag,index,0}, held stable until mem_req_ready.
REQ-016 After the mem_req handshake SHALL enter REFILL, write beat k to word k on each mem_resp_valid; beats outside REFILL ignored.
REQ-017 On beat W-1 SHALL write tag, set valid[index], return to IDLE, and assert resp_valid the following cycle with data from the filled line.
REQ-018 Slot i SHALL hold word offset+i when offset+i < W, batch_mask[i]=1; else 32'h00000013 (NOP, zero-extended/truncated to WORD_WIDTH), batch_mask[i]=0. Batches never cross a line.
REQ-019 resp_valid, inst_batch, batch_mask SHALL stay stable until resp_valid && resp_ready; resp_valid drops next cycle unless a new hit is accepted the same cycle (back-to-back hits at 1/cycle).
REQ-020 flush SHALL clear all valid bits at the next edge; flush during MISS_REQ/REFILL SHALL let the refill finish and return its response but leave that line invalid.
REQ-021 Offset/index arithmetic SHALL use (log2(W)+1)-bit sums to avoid wrap.

Reset
REQ-022 rst SHALL force state IDLE, all valid bits 0, beat counter 0, resp_valid 0, mem_req_valid 0, inst_batch 0, batch_mask 0; data array not reset.
REQ-023 rst mid-MISS_REQ/REFILL SHALL abandon the refill; later mem_resp beats ignored; the line stays invalid.

Configuration
REQ-024 With ICACHE_PERF_CNT_EN defined SHALL add outputs hit_cnt, miss_cnt (32-bit, reset 0, +1 per accepted hit/miss, wrap at 2^32); without it the ports and counters SHALL not exist and behaviour is otherwise identical.

Verification (LINE_NUM=4, W=16, FETCH_WIDTH=4, ADDR_WIDTH=16, memory word k of line L = 0x1000*L' + k, L'=line addr>>4)
REQ-025 Cold fetch 0x0005 -> mem_req_addr 0x0000, 16 beats, then resp inst_batch {0x0005..0x0008}, mask 4'b1111.
REQ-026 Fetch 0x0006 after REQ-025 -> resp_valid next cycle, no mem_req_valid, mask 4'b1111.
REQ-027 Fetch 0x000E -> slots {0x000E,0x000F,0x00000013,0x00000013}, mask 4'b0011.
REQ-028 Fetch 0x0040 (index 0, new tag) -> miss, mem_req_addr 0x0040; then 0x0005 misses again.
REQ-029 flush pulse, then fetch 0x0006 -> miss and refill; with ICACHE_PERF_CNT_EN miss_cnt increments by 1.
REQ-030 rst after 7 REFILL beats -> mem_req_valid 0, resp_valid 0; re-fetch same address issues a fresh mem_req.
